// File: rtl/bit_serializer_pkg.sv
// Shared definitions for the bit serializer: FSM state encoding and word counter width.
package bit_serializer_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } ser_state_e;

    localparam int unsigned WORD_CNT_W = 16;

endpackage

// File: rtl/bit_hold_buf.sv
// One-word hold buffer in front of the shifter; ready is registered so the
// producer handshake never sees a combinational path from en or load_valid.
module bit_hold_buf #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             ready,
    output logic [WIDTH-1:0] hold_data,
    output logic             full_next_c
);

    // push only happens while ready=1 (buffer empty), so push and pop never collide
    always_comb begin
        full_next_c = push | (full & ~pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full      <= 1'b0;
            ready     <= 1'b1;
            hold_data <= '0;
        end else begin
            full  <= full_next_c;
            ready <= ~full_next_c;
            if (push) begin
                hold_data <= push_data;
            end
        end
    end

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter with a one-word hold buffer, enable-gated bit
// rate and a wrapping count of completed words.
module bit_serializer
    import bit_serializer_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MSB_FIRST = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  load_valid,
    input  logic [WIDTH-1:0]      load_data,
    output logic                  load_ready,
    output logic                  data,
    output logic                  data_valid,
    output logic                  busy,
    output logic [WORD_CNT_W-1:0] word_cnt
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    ser_state_e             state, state_nxt;
    logic [WIDTH-1:0]       sreg, sreg_nxt;
    logic [CNT_W-1:0]       bit_cnt, bit_cnt_nxt;
    logic                   data_nxt;
    logic                   valid_nxt;
    logic [WORD_CNT_W-1:0]  cnt_nxt;
    logic                   busy_nxt;

    logic                   accept;
    logic                   take_direct;
    logic                   push;
    logic                   pop;
    logic                   start;
    logic [WIDTH-1:0]       start_word;
    logic                   hold_full;
    logic                   hold_full_nxt;
    logic [WIDTH-1:0]       hold_data;

    // Bit presented first / remainder after presenting one bit, in the configured order
    function automatic logic lead_bit(input logic [WIDTH-1:0] w);
        return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] drop_lead(input logic [WIDTH-1:0] w);
        return (MSB_FIRST != 0) ? (w << 1) : (w >> 1);
    endfunction

    bit_hold_buf #(
        .WIDTH(WIDTH)
    ) u_hold (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_data  (load_data),
        .pop        (pop),
        .full       (hold_full),
        .ready      (load_ready),
        .hold_data  (hold_data),
        .full_next_c(hold_full_nxt)
    );

    // Next-state and output decode
    always_comb begin
        state_nxt   = state;
        sreg_nxt    = sreg;
        bit_cnt_nxt = bit_cnt;
        data_nxt    = data;
        valid_nxt   = data_valid;
        cnt_nxt     = word_cnt;
        pop         = 1'b0;
        take_direct = 1'b0;
        start       = 1'b0;
        start_word  = '0;
        accept      = load_valid & load_ready;

        unique case (state)
            ST_IDLE: begin
                if (en) begin
                    if (hold_full) begin
                        pop        = 1'b1;
                        start      = 1'b1;
                        start_word = hold_data;
                    end else if (accept) begin
                        take_direct = 1'b1;
                        start       = 1'b1;
                        start_word  = load_data;
                    end
                end
            end
            ST_SHIFT: begin
                if (en) begin
                    if (bit_cnt == LAST_BIT) begin
                        cnt_nxt = word_cnt + 1'b1;
                        if (hold_full) begin
                            pop        = 1'b1;
                            start      = 1'b1;
                            start_word = hold_data;
                        end else if (accept) begin
                            take_direct = 1'b1;
                            start       = 1'b1;
                            start_word  = load_data;
                        end else begin
                            state_nxt   = ST_IDLE;
                            sreg_nxt    = '0;
                            bit_cnt_nxt = '0;
                            data_nxt    = 1'b0;
                            valid_nxt   = 1'b0;
                        end
                    end else begin
                        bit_cnt_nxt = bit_cnt + 1'b1;
                        data_nxt    = lead_bit(sreg);
                        sreg_nxt    = drop_lead(sreg);
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // A new word puts its first bit on data from this edge on
        if (start) begin
            state_nxt   = ST_SHIFT;
            bit_cnt_nxt = '0;
            data_nxt    = lead_bit(start_word);
            sreg_nxt    = drop_lead(start_word);
            valid_nxt   = 1'b1;
        end

        push     = accept & ~take_direct;
        busy_nxt = (state_nxt == ST_SHIFT) | hold_full_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            sreg       <= '0;
            bit_cnt    <= '0;
            data       <= 1'b0;
            data_valid <= 1'b0;
            word_cnt   <= '0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            sreg       <= sreg_nxt;
            bit_cnt    <= bit_cnt_nxt;
            data       <= data_nxt;
            data_valid <= valid_nxt;
            word_cnt   <= cnt_nxt;
            busy       <= busy_nxt;
        end
    end

endmodule
